// File: rtl/histogram_equalizer.sv
`timescale 1ns/1ps
// histogram_equalizer: in-place histogram equalization of the image held in image RAM.
// For each pixel in raster order: read the pixel, look up its CDF word, divide
// (cdf - CDF_min) * (2^PIXEL_WIDTH - 1) by (N - CDF_min) with a restoring divider,
// then write the equalized value back to the same address.
// Ports:
//   clk, rst (sync, active high)         - clock / reset
//   start, CDF_min                       - pass trigger and minimum non-zero CDF
//   image_RAM_* (address/data/CE/WE)     - pixel read and write-back port
//   histogram_RAM_* (address/data/CE/WE) - CDF lookup port (WE tied low)
//   busy, done                           - pass in progress / last pixel written pulse
module histogram_equalizer #(
  parameter int unsigned IMAGE_WIDTH              = 320,
  parameter int unsigned IMAGE_HEIGHT             = 240,
  parameter int unsigned PIXEL_WIDTH              = 8,
  parameter int unsigned IMAGE_RAM_ADDRESS_WIDTH  = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT),
  parameter int unsigned HISTOGRAM_RAM_DATA_WIDTH = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [HISTOGRAM_RAM_DATA_WIDTH-1:0] CDF_min,
  output logic [IMAGE_RAM_ADDRESS_WIDTH-1:0]  image_RAM_address,
  input  logic [PIXEL_WIDTH-1:0]              image_RAM_data_input,
  output logic [PIXEL_WIDTH-1:0]              image_RAM_data_output,
  output logic                                image_RAM_CE,
  output logic                                image_RAM_WE,
  output logic [PIXEL_WIDTH-1:0]              histogram_RAM_address,
  input  logic [HISTOGRAM_RAM_DATA_WIDTH-1:0] histogram_RAM_data_input,
  output logic                                histogram_RAM_CE,
  output logic                                histogram_RAM_WE,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned PW   = PIXEL_WIDTH;
  localparam int unsigned AW   = IMAGE_RAM_ADDRESS_WIDTH;
  localparam int unsigned HW   = HISTOGRAM_RAM_DATA_WIDTH;
  localparam int unsigned NW   = HW + PW;            // numerator / remainder width
  localparam int unsigned DW   = HW + 1;             // divisor width, holds N without wrap
  localparam int unsigned CW   = $clog2(PW + 1);
  localparam int unsigned NPIX = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int unsigned MAXV = (1 << PW) - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_PIX, S_LAT_PIX, S_RD_CDF, S_LAT_CDF, S_DIV, S_WR, S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [HW-1:0]  cdf_min_q, cdf_min_d;
  logic [PW-1:0]  pix_q, pix_d;
  logic [NW-1:0]  rem_q, rem_d;
  logic [NW-1:0]  dsh_q, dsh_d;      // divisor aligned to the quotient bit under test
  logic [PW-1:0]  quo_q, quo_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           below_q, below_d;  // cdf < CDF_min: result forced to 0
  logic           pass_q, pass_d;    // divisor zero: pixel written back unchanged

  logic [AW-1:0]  img_addr_q, img_addr_d;
  logic [PW-1:0]  img_dout_q, img_dout_d;
  logic           img_ce_q, img_ce_d, img_we_q, img_we_d;
  logic [PW-1:0]  hist_addr_q, hist_addr_d;
  logic           hist_ce_q, hist_ce_d;
  logic           busy_q, busy_d, done_q, done_d;

  logic [DW-1:0]  divisor;
  logic [NW-1:0]  trial;
  logic           ge;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cdf_min_d   = cdf_min_q;
    pix_d       = pix_q;
    rem_d       = rem_q;
    dsh_d       = dsh_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    below_d     = below_q;
    pass_d      = pass_q;
    img_addr_d  = img_addr_q;
    img_dout_d  = img_dout_q;
    hist_addr_d = hist_addr_q;

    divisor = DW'(NPIX) - {1'b0, cdf_min_q};
    trial   = rem_q - dsh_q;
    ge      = (rem_q >= dsh_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cdf_min_d = CDF_min;
          idx_d     = '0;
          state_d   = S_RD_PIX;
        end
      end
      S_RD_PIX:  state_d = S_LAT_PIX;
      S_LAT_PIX: begin
        pix_d   = image_RAM_data_input;
        state_d = S_RD_CDF;
      end
      S_RD_CDF:  state_d = S_LAT_CDF;
      S_LAT_CDF: begin
        below_d = (histogram_RAM_data_input < cdf_min_q);
        pass_d  = (divisor == '0);
        rem_d   = NW'(histogram_RAM_data_input - cdf_min_q) * NW'(MAXV);
        dsh_d   = NW'(divisor) << (PW - 1);
        quo_d   = '0;
        cnt_d   = '0;
        state_d = S_DIV;
      end
      S_DIV: begin
        // One restoring step per cycle, quotient MSB first
        quo_d = PW'({quo_q, ge});
        if (ge) rem_d = trial;
        dsh_d = dsh_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(PW - 1)) begin
          state_d    = S_WR;
          img_dout_d = below_q ? '0 : (pass_q ? pix_q : quo_d);
        end
      end
      S_WR: begin
        if (idx_q == AW'(NPIX - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = S_RD_PIX;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes follow the state being entered so they are registered yet in-phase
    img_ce_d  = (state_d == S_RD_PIX) || (state_d == S_WR);
    img_we_d  = (state_d == S_WR);
    hist_ce_d = (state_d == S_RD_CDF);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    if ((state_d == S_RD_PIX) || (state_d == S_WR)) img_addr_d = idx_d;
    if (state_d == S_RD_CDF) hist_addr_d = pix_d;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cdf_min_q   <= '0;
      pix_q       <= '0;
      rem_q       <= '0;
      dsh_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      below_q     <= 1'b0;
      pass_q      <= 1'b0;
      img_addr_q  <= '0;
      img_dout_q  <= '0;
      img_ce_q    <= 1'b0;
      img_we_q    <= 1'b0;
      hist_addr_q <= '0;
      hist_ce_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cdf_min_q   <= cdf_min_d;
      pix_q       <= pix_d;
      rem_q       <= rem_d;
      dsh_q       <= dsh_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      below_q     <= below_d;
      pass_q      <= pass_d;
      img_addr_q  <= img_addr_d;
      img_dout_q  <= img_dout_d;
      img_ce_q    <= img_ce_d;
      img_we_q    <= img_we_d;
      hist_addr_q <= hist_addr_d;
      hist_ce_q   <= hist_ce_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign image_RAM_address     = img_addr_q;
  assign image_RAM_data_output = img_dout_q;
  assign image_RAM_CE          = img_ce_q;
  assign image_RAM_WE          = img_we_q;
  assign histogram_RAM_address = hist_addr_q;
  assign histogram_RAM_CE      = hist_ce_q;
  assign histogram_RAM_WE      = 1'b0;
  assign busy                  = busy_q;
  assign done                  = done_q;

endmodule

// File: tb/tb_histogram_equalizer.sv
`timescale 1ns/1ps
// Bench for histogram_equalizer on an 8x8 image with behavioural RAMs and a
// write/read scoreboard fed from a formula-level reference.
module tb_histogram_equalizer;

  localparam int unsigned NPIX = 64;
  localparam int unsigned PW   = 8;
  localparam int unsigned AW   = 6;
  localparam int unsigned HW   = 7;
  localparam int          LAT  = 13 * 64 + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [HW-1:0] cdf_min;
  logic [AW-1:0] image_RAM_address;
  logic [PW-1:0] img_rd;
  logic [PW-1:0] image_RAM_data_output;
  logic          image_RAM_CE, image_RAM_WE;
  logic [PW-1:0] histogram_RAM_address;
  logic [HW-1:0] hist_rd;
  logic          histogram_RAM_CE, histogram_RAM_WE;
  logic          busy, done;

  histogram_equalizer #(
    .IMAGE_WIDTH(8), .IMAGE_HEIGHT(8), .PIXEL_WIDTH(PW),
    .IMAGE_RAM_ADDRESS_WIDTH(AW), .HISTOGRAM_RAM_DATA_WIDTH(HW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .CDF_min(cdf_min),
    .image_RAM_address(image_RAM_address), .image_RAM_data_input(img_rd),
    .image_RAM_data_output(image_RAM_data_output),
    .image_RAM_CE(image_RAM_CE), .image_RAM_WE(image_RAM_WE),
    .histogram_RAM_address(histogram_RAM_address),
    .histogram_RAM_data_input(hist_rd),
    .histogram_RAM_CE(histogram_RAM_CE), .histogram_RAM_WE(histogram_RAM_WE),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [PW-1:0] img  [0:NPIX-1];
  logic [HW-1:0] hist [0:255];
  logic [PW-1:0] snap [0:NPIX-1];

  typedef struct { int addr; int data; } wr_t;
  wr_t wr_q[$];
  int  rd_q[$];
  int  n_cmp  = 0;
  int  n_err  = 0;
  int  wr_cnt = 0;

  // Synchronous RAMs, one-cycle read latency
  always @(posedge clk) begin
    if (image_RAM_CE) begin
      if (image_RAM_WE) img[image_RAM_address] = image_RAM_data_output;
      else              img_rd <= img[image_RAM_address];
    end
    if (histogram_RAM_CE) hist_rd <= hist[histogram_RAM_address];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_eq(input int pix, input int cdf, input int cmin);
    if (cdf < cmin)          return 0;
    if (cmin == int'(NPIX))  return pix;
    return ((cdf - cmin) * 255) / (int'(NPIX) - cmin);
  endfunction

  // Expected traffic for a full pass, from the image contents before the pass
  task automatic push_expect(input int cmin);
    for (int i = 0; i < int'(NPIX); i++) begin
      snap[i] = img[i];
      wr_q.push_back('{addr: i, data: ref_eq(int'(img[i]), int'(hist[img[i]]), cmin)});
      rd_q.push_back(i);
    end
    wr_cnt = 0;
  endtask

  // Monitor: compares every write and read strobe against the scoreboard
  always @(negedge clk) begin : mon
    wr_t e;
    int  ra;
    if (image_RAM_CE && image_RAM_WE) begin
      wr_cnt++;
      if (wr_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_write: got write addr %0d data %0d, expected none",
                 image_RAM_address, image_RAM_data_output);
      end else begin
        e = wr_q.pop_front();
        chk("wr_addr", int'(image_RAM_address), e.addr);
        chk("wr_data", int'(image_RAM_data_output), e.data);
      end
    end else if (image_RAM_CE) begin
      if (rd_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_read: got read addr %0d, expected none", image_RAM_address);
      end else begin
        ra = rd_q.pop_front();
        chk("rd_addr", int'(image_RAM_address), ra);
      end
    end
    if (histogram_RAM_CE) chk("hist_we", int'(histogram_RAM_WE), 0);
  end

  // One full pass; optional stray start pulse sampled at edge inj
  task automatic run_pass(input int cmin, input int inj);
    int n;
    @(negedge clk);
    push_expect(cmin);
    cdf_min = HW'(cmin);
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    chk("busy_first", int'(busy), 1);
    while (done !== 1'b1 && n < 2000) begin
      start = (n == inj);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("done_latency", n, LAT);
    chk("write_count", wr_cnt, int'(NPIX));
    chk("queue_left", wr_q.size(), 0);
    @(negedge clk);
    chk("busy_after", int'(busy), 0);
    chk("done_pulse", int'(done), 0);
  endtask

  task automatic random_image_with_cdf(output int cmin);
    int cnt [0:255];
    int cum;
    for (int v = 0; v < 256; v++) cnt[v] = 0;
    for (int i = 0; i < int'(NPIX); i++) begin
      img[i] = PW'($urandom_range(0, 255));
      cnt[img[i]]++;
    end
    cum  = 0;
    cmin = 0;
    for (int v = 0; v < 256; v++) begin
      cum += cnt[v];
      hist[v] = HW'(cum);
      if (cmin == 0 && cum != 0) cmin = cum;
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cmin;
    int changed;
    rst = 1'b1; start = 1'b0; cdf_min = '0;
    for (int i = 0; i < int'(NPIX); i++) img[i] = '0;
    for (int v = 0; v < 256; v++) hist[v] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_img_ce", int'(image_RAM_CE), 0);
    chk("rst_img_we", int'(image_RAM_WE), 0);
    chk("rst_hist_ce", int'(histogram_RAM_CE), 0);
    chk("rst_img_addr", int'(image_RAM_address), 0);
    chk("rst_img_dout", int'(image_RAM_data_output), 0);
    chk("rst_hist_addr", int'(histogram_RAM_address), 0);
    rst = 1'b0;

    // Directed linear map with endpoints, plus a stray start while busy
    for (int i = 0; i < int'(NPIX); i++) begin
      case (i % 4)
        0: img[i] = 8'd0;
        1: img[i] = 8'd3;
        2: img[i] = 8'd255;
        default: img[i] = 8'd100;
      endcase
    end
    img[5] = 8'd10;
    hist[0] = 7'd2;
    for (int v = 1; v < 10; v++) hist[v] = 7'd4;
    hist[10] = 7'd34;
    for (int v = 11; v < 255; v++) hist[v] = 7'd50;
    hist[255] = 7'd64;
    run_pass(4, 100);
    chk("linear_px5", int'(img[5]), 127);
    chk("cdf_max_px6", int'(img[6]), 255);
    chk("cdf_eq_min_px1", int'(img[1]), 0);
    chk("cdf_below_min_px0", int'(img[0]), 0);
    chk("px3_mid", int'(img[3]), 195);

    // Restart right after done
    run_pass(4, -1);

    // Single-valued image: divisor zero, pixels kept
    for (int i = 0; i < int'(NPIX); i++) img[i] = 8'd77;
    hist[77] = 7'd64;
    run_pass(64, -1);
    chk("uniform_px0", int'(img[0]), 77);
    chk("uniform_px63", int'(img[63]), 77);

    // Reset sampled at edge 300 of a pass
    random_image_with_cdf(cmin);
    @(negedge clk);
    push_expect(cmin);
    cdf_min = HW'(cmin);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n < 300; n++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_img_ce", int'(image_RAM_CE), 0);
    chk("mid_rst_img_we", int'(image_RAM_WE), 0);
    chk("mid_rst_hist_ce", int'(histogram_RAM_CE), 0);
    repeat (40) @(negedge clk);
    chk("mid_rst_writes", wr_cnt, 23);
    changed = 0;
    for (int i = 23; i < int'(NPIX); i++) if (img[i] != snap[i]) changed++;
    chk("mid_rst_untouched", changed, 0);
    wr_q.delete();
    rd_q.delete();

    // Randomized images with their real cumulative histograms
    for (int r = 0; r < 3; r++) begin
      random_image_with_cdf(cmin);
      run_pass(cmin, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
